// File: rtl/invers_shift_row_byte_sub.sv
// AES inverse ShiftRows + inverse SubBytes applied in place to a 16-word state
// memory: read all 16 bytes into a local buffer, then look each one up and write it back.
module invers_shift_row_byte_sub (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic [4:0]  statemt_address0,
    output logic        statemt_ce0,
    output logic        statemt_we0,
    output logic [31:0] statemt_d0,
    input  logic [31:0] statemt_q0,
    output logic [4:0]  statemt_address1,
    output logic        statemt_ce1,
    output logic        statemt_we1,
    output logic [31:0] statemt_d1,
    input  logic [31:0] statemt_q1,
    output logic [7:0]  inv_sbox_address0,
    output logic        inv_sbox_ce0,
    input  logic [7:0]  inv_sbox_q0
);

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned NWORDS   = 16;
    localparam int unsigned K_W      = 4;
    localparam int unsigned M_W      = 5;
    localparam int unsigned RD_LAST  = 8;
    localparam int unsigned SUB_LAST = 16;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_READ = 4'b0010,
        S_SUB  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t                          state_q, state_d;
    logic [K_W-1:0]                  k_q, k_d;
    logic [M_W-1:0]                  m_q, m_d;
    logic [NWORDS-1:0][BYTE_W-1:0]   buf_q, buf_d;
    logic [2:0]                      km1;

    logic [ADDR_W-1:0] addr0_q, addr0_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic              ce0_q, ce0_d;
    logic              ce1_q, ce1_d;
    logic              we0_q, we0_d;
    logic [BYTE_W-1:0] sbox_addr_q, sbox_addr_d;
    logic              sbox_ce_q, sbox_ce_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic              unused_q_hi;

    // Output byte r+4c takes its source from column (c - r) mod 4 of the same row.
    function automatic logic [3:0] src_idx(input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] c;
        r = m[1:0];
        c = m[3:2];
        return {2'(c - r), r};
    endfunction

    assign km1 = 3'(k_q - K_W'(1));

    // Next state, counters and buffer capture.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        m_d     = m_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = S_READ;
                    k_d     = '0;
                    m_d     = '0;
                end
            end
            S_READ: begin
                if (k_q != '0) begin
                    buf_d[{km1, 1'b0}] = statemt_q0[BYTE_W-1:0];
                    buf_d[{km1, 1'b1}] = statemt_q1[BYTE_W-1:0];
                end
                if (k_q == K_W'(RD_LAST)) begin
                    state_d = S_SUB;
                    m_d     = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_SUB: begin
                if (m_q == M_W'(SUB_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    m_d = m_q + M_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (ap_rst) begin
            state_d = S_IDLE;
            k_d     = '0;
            m_d     = '0;
        end
    end

    // Memory/ROM controls for the coming cycle, decoded from the next state.
    // buf_q suffices for the lookup: the final capture (entries 14/15) never feeds slot m=0.
    always_comb begin
        addr0_d     = '0;
        addr1_d     = '0;
        ce0_d       = 1'b0;
        ce1_d       = 1'b0;
        we0_d       = 1'b0;
        sbox_addr_d = '0;
        sbox_ce_d   = 1'b0;
        done_d      = 1'b0;
        ready_d     = 1'b0;
        case (state_d)
            S_READ: begin
                if (k_d < K_W'(RD_LAST)) begin
                    ce0_d   = 1'b1;
                    ce1_d   = 1'b1;
                    addr0_d = ADDR_W'({k_d[2:0], 1'b0});
                    addr1_d = ADDR_W'({k_d[2:0], 1'b1});
                end
            end
            S_SUB: begin
                if (m_d < M_W'(SUB_LAST)) begin
                    sbox_ce_d   = 1'b1;
                    sbox_addr_d = buf_q[src_idx(m_d[3:0])];
                end
                if (m_d != '0) begin
                    ce0_d   = 1'b1;
                    we0_d   = 1'b1;
                    addr0_d = ADDR_W'(m_d - M_W'(1));
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                ready_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            m_q         <= '0;
            addr0_q     <= '0;
            addr1_q     <= '0;
            ce0_q       <= 1'b0;
            ce1_q       <= 1'b0;
            we0_q       <= 1'b0;
            sbox_addr_q <= '0;
            sbox_ce_q   <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            m_q         <= m_d;
            addr0_q     <= addr0_d;
            addr1_q     <= addr1_d;
            ce0_q       <= ce0_d;
            ce1_q       <= ce1_d;
            we0_q       <= we0_d;
            sbox_addr_q <= sbox_addr_d;
            sbox_ce_q   <= sbox_ce_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    // Byte buffer carries no reset; it is always filled before being read.
    always_ff @(posedge ap_clk) begin
        buf_q <= buf_d;
    end

    // Enables are masked by reset so an aborting run cannot land one more write.
    assign statemt_address0  = addr0_q;
    assign statemt_address1  = addr1_q;
    assign statemt_ce0       = ce0_q & ~ap_rst;
    assign statemt_ce1       = ce1_q & ~ap_rst;
    assign statemt_we0       = we0_q & ~ap_rst;
    assign statemt_we1       = 1'b0;
    assign statemt_d0        = DATA_W'(inv_sbox_q0);
    assign statemt_d1        = '0;
    assign inv_sbox_address0 = sbox_addr_q;
    assign inv_sbox_ce0      = sbox_ce_q & ~ap_rst;
    assign ap_done           = done_q;
    assign ap_ready          = ready_q;
    assign ap_idle           = (state_q == S_IDLE) && !ap_start;

    assign unused_q_hi = ^{statemt_q0[DATA_W-1:BYTE_W], statemt_q1[DATA_W-1:BYTE_W]};

endmodule

// File: tb/tb_invers_shift_row_byte_sub.sv
// Bench for invers_shift_row_byte_sub: behavioural state RAM and inverse S-box ROM,
// table of directed vectors plus hand-written back-to-back, reset and stray-start runs.
module tb_invers_shift_row_byte_sub;

    logic        ap_clk;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [4:0]  statemt_address0, statemt_address1;
    logic        statemt_ce0, statemt_ce1, statemt_we0, statemt_we1;
    logic [31:0] statemt_d0, statemt_d1, statemt_q0, statemt_q1;
    logic [7:0]  inv_sbox_address0, inv_sbox_q0;
    logic        inv_sbox_ce0;

    int checks = 0;
    int errors = 0;
    int addr4_viol = 0;

    logic [31:0] mem [32];
    logic        load_en = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [31:0] load_data = '0;

    logic [7:0] invs [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    // Hand-computed results, index order 0..15.
    logic [7:0] ramp_exp [16] = '{8'h52,8'hf3,8'ha3,8'h38,8'h30,8'h09,8'hd7,8'h9e,
                                  8'hbf,8'h36,8'h6a,8'hfb,8'h81,8'h40,8'ha5,8'hd5};
    logic [7:0] hi_exp   [16] = '{8'h7c,8'hde,8'h43,8'h87,8'h9b,8'he3,8'he9,8'h44,
                                  8'h34,8'h2f,8'h39,8'hcb,8'hc4,8'h8e,8'hff,8'h82};

    typedef struct packed {
        logic [15:0][31:0] init_w;
        logic [15:0][31:0] exp_w;
    } vec_t;

    vec_t vecs [4];

    invers_shift_row_byte_sub dut (
        .ap_clk            (ap_clk),
        .ap_rst            (ap_rst),
        .ap_start          (ap_start),
        .ap_done           (ap_done),
        .ap_idle           (ap_idle),
        .ap_ready          (ap_ready),
        .statemt_address0  (statemt_address0),
        .statemt_ce0       (statemt_ce0),
        .statemt_we0       (statemt_we0),
        .statemt_d0        (statemt_d0),
        .statemt_q0        (statemt_q0),
        .statemt_address1  (statemt_address1),
        .statemt_ce1       (statemt_ce1),
        .statemt_we1       (statemt_we1),
        .statemt_d1        (statemt_d1),
        .statemt_q1        (statemt_q1),
        .inv_sbox_address0 (inv_sbox_address0),
        .inv_sbox_ce0      (inv_sbox_ce0),
        .inv_sbox_q0       (inv_sbox_q0)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Dual-port RAM and ROM, both with one-cycle read latency.
    always @(posedge ap_clk) begin
        if (load_en) mem[load_addr] <= load_data;
        if (statemt_ce0) begin
            if (statemt_we0) mem[statemt_address0] <= statemt_d0;
            statemt_q0 <= mem[statemt_address0];
        end
        if (statemt_ce1) begin
            if (statemt_we1) mem[statemt_address1] <= statemt_d1;
            statemt_q1 <= mem[statemt_address1];
        end
        if (inv_sbox_ce0) inv_sbox_q0 <= invs[inv_sbox_address0];
        if ((statemt_ce0 && statemt_address0[4]) || (statemt_ce1 && statemt_address1[4]))
            addr4_viol <= addr4_viol + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [15:0][31:0] w);
        for (int i = 0; i < 16; i++) begin
            @(negedge ap_clk);
            load_en   = 1'b1;
            load_addr = 5'(i);
            load_data = w[i];
        end
        @(negedge ap_clk);
        load_en = 1'b0;
    endtask

    function automatic logic [4:0] ctl();
        return {statemt_ce0, statemt_ce1, statemt_we0, statemt_we1, inv_sbox_ce0};
    endfunction

    initial begin
        int done_at, done2_at, ndone, early_we, late_we, idle_bad;

        for (int k = 0; k < 16; k++) begin
            vecs[0].init_w[k] = 32'h0;
            vecs[0].exp_w[k]  = 32'h52;
            vecs[1].init_w[k] = 32'(k);
            vecs[1].exp_w[k]  = {24'h0, ramp_exp[k]};
            vecs[2].init_w[k] = (k == 0) ? 32'hFFFFFF63 : 32'h0;
            vecs[2].exp_w[k]  = (k == 0) ? 32'h0 : 32'h52;
            vecs[3].init_w[k] = 32'hDEADBE10 + 32'(k);
            vecs[3].exp_w[k]  = {24'h0, hi_exp[k]};
        end

        ap_rst   = 1'b1;
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        #1;
        chk("reset_idle", 32'(ap_idle), 32'd1);
        chk("reset_done_ready", 32'({ap_done, ap_ready}), 32'd0);
        chk("reset_ce_we", 32'(ctl()), 32'd0);

        // Table-driven full runs.
        for (int v = 0; v < 4; v++) begin
            load_mem(vecs[v].init_w);
            @(negedge ap_clk);
            ap_start = 1'b1;
            done_at = 0; ndone = 0; early_we = 0;
            for (int n = 1; n <= 40; n++) begin
                @(negedge ap_clk);
                ap_start = 1'b0;
                #1;
                if (ap_done) begin
                    ndone++;
                    if (done_at == 0) done_at = n;
                    chk($sformatf("v%0d_ready_with_done", v), 32'(ap_ready), 32'd1);
                end
                if (n <= 10 && (statemt_we0 || statemt_we1)) early_we++;
                if (n == 5) chk($sformatf("v%0d_busy_not_idle", v), 32'(ap_idle), 32'd0);
                if (n == 28) chk($sformatf("v%0d_idle_after", v), 32'(ap_idle), 32'd1);
            end
            chk($sformatf("v%0d_done_latency", v), 32'(done_at), 32'd27);
            chk($sformatf("v%0d_done_count", v), 32'(ndone), 32'd1);
            chk($sformatf("v%0d_write_during_read", v), 32'(early_we), 32'd0);
            for (int i = 0; i < 16; i++)
                chk($sformatf("v%0d_statemt%0d", v, i), mem[i], vecs[v].exp_w[i]);
        end

        // Back-to-back with ap_start held high.
        load_mem(vecs[0].init_w);
        @(negedge ap_clk);
        ap_start = 1'b1;
        done_at = 0; done2_at = 0; ndone = 0; idle_bad = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge ap_clk);
            if (n == 56) ap_start = 1'b0;
            #1;
            if (ap_done) begin
                ndone++;
                if (done_at == 0) done_at = n;
                else if (done2_at == 0) done2_at = n;
            end
            if (n <= 55 && ap_idle) idle_bad++;
            if (n == 56) chk("b2b_idle_end", 32'(ap_idle), 32'd1);
        end
        chk("b2b_done1", 32'(done_at), 32'd27);
        chk("b2b_done2", 32'(done2_at), 32'd55);
        chk("b2b_done_count", 32'(ndone), 32'd2);
        chk("b2b_idle_low", 32'(idle_bad), 32'd0);
        chk("b2b_statemt0", mem[0], 32'h48);
        chk("b2b_statemt15", mem[15], 32'h48);

        // Reset in the middle of the substitution phase.
        load_mem(vecs[1].init_w);
        @(negedge ap_clk);
        ap_start = 1'b1;
        ndone = 0; late_we = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            ap_rst   = (n == 15);
            #1;
            if (ap_done) ndone++;
            if (n >= 16 && (statemt_we0 || statemt_we1)) late_we++;
            if (n == 16) begin
                chk("rst_idle", 32'(ap_idle), 32'd1);
                chk("rst_ce_we", 32'(ctl()), 32'd0);
            end
        end
        chk("rst_no_done", 32'(ndone), 32'd0);
        chk("rst_no_late_write", 32'(late_we), 32'd0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("rst_statemt%0d", i), mem[i],
                (i < 4) ? {24'h0, ramp_exp[i]} : 32'(i));

        // Stray start pulse during a run.
        load_mem(vecs[0].init_w);
        @(negedge ap_clk);
        ap_start = 1'b1;
        done_at = 0; ndone = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge ap_clk);
            ap_start = (n == 5);
            #1;
            if (ap_done) begin
                ndone++;
                if (done_at == 0) done_at = n;
            end
            if (n == 28) chk("stray_idle_after", 32'(ap_idle), 32'd1);
        end
        chk("stray_done_latency", 32'(done_at), 32'd27);
        chk("stray_done_count", 32'(ndone), 32'd1);
        chk("stray_statemt7", mem[7], 32'h52);

        chk("address_bit4", 32'(addr4_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
